// File: rtl/proc_mem_responder_if.sv
// CPU-side bus of the 6502 memory responder: address, direction and data
// from the core, read data and ready back to it.
interface proc_mem_responder_if;
  logic [15:0] AB;
  logic        RW;
  logic [7:0]  DB_OUT;
  logic [7:0]  DB_IN;
  logic        RDY;

  modport master (output AB, RW, DB_OUT, input DB_IN, RDY);
  modport slave  (input AB, RW, DB_OUT, output DB_IN, RDY);
endinterface

// File: rtl/proc_mem_responder.sv
// Turns 6502 bus cycles into accesses on a synchronous single-port memory,
// stalling the CPU with RDY for read latency and wait states and blocking ROM writes.
module proc_mem_responder #(
  parameter int          MEM_ADDR_WIDTH = 16,
  parameter int          READ_LATENCY   = 1,
  parameter int          WAIT_STATES    = 0,
  parameter logic [15:0] ROM_BASE       = 16'hE000
) (
  input  logic                      PHI_2,
  input  logic                      RES,
  proc_mem_responder_if.slave       bus,
  output logic                      ena,
  output logic                      wea,
  output logic [MEM_ADDR_WIDTH-1:0] addra,
  output logic [7:0]                dina,
  input  logic [7:0]                douta,
  output logic                      rom_wr_err,
  output logic [7:0]                rom_wr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY + WAIT_STATES);
  localparam logic [3:0] WR_LOAD = 4'(WAIT_STATES);
  // RD_WAIT counter value during the cycle READ_LATENCY after issue
  localparam logic [3:0] CAP_AT  = 4'(WAIT_STATES + 1);

  state_t     state_r;
  state_t     state_nxt;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt;
  logic [7:0] db_in_r;
  logic       rdy_s;
  logic       capture_s;
  logic       rom_hit_s;
  logic       is_rom_s;

  assign is_rom_s = (bus.AB >= ROM_BASE);
  assign bus.DB_IN = db_in_r;
  assign bus.RDY   = rdy_s;

  // Next-state, counter and memory-port decode; reset forces the port quiet
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    rdy_s     = 1'b1;
    ena       = 1'b0;
    wea       = 1'b0;
    addra     = '0;
    dina      = 8'h00;
    capture_s = 1'b0;
    rom_hit_s = 1'b0;
    if (!RES) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.RW) begin
            ena       = 1'b1;
            addra     = bus.AB[MEM_ADDR_WIDTH-1:0];
            rdy_s     = 1'b0;
            state_nxt = RD_WAIT;
            cnt_nxt   = RD_LOAD;
          end else begin
            if (is_rom_s) begin
              rom_hit_s = 1'b1;
            end else begin
              ena   = 1'b1;
              wea   = 1'b1;
              addra = bus.AB[MEM_ADDR_WIDTH-1:0];
              dina  = bus.DB_OUT;
            end
            if (WAIT_STATES == 0) begin
              rdy_s = 1'b1;
            end else begin
              rdy_s     = 1'b0;
              state_nxt = WR_WAIT;
              cnt_nxt   = WR_LOAD;
            end
          end
        end
        RD_WAIT: begin
          rdy_s     = 1'b0;
          capture_s = (cnt_r == CAP_AT);
          cnt_nxt   = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt_r == 4'd1) begin
            rdy_s     = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end else begin
            rdy_s   = 1'b0;
            cnt_nxt = cnt_r - 4'd1;
          end
        end
        DONE: begin
          rdy_s     = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State, counter, read-data capture and ROM write bookkeeping
  always_ff @(posedge PHI_2 or negedge RES) begin
    if (!RES) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      db_in_r      <= 8'h00;
      rom_wr_err   <= 1'b0;
      rom_wr_count <= 8'h00;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      rom_wr_err <= rom_hit_s;
      if (capture_s) begin
        db_in_r <= douta;
      end else begin
        db_in_r <= db_in_r;
      end
      if (rom_hit_s && (rom_wr_count != 8'hFF)) begin
        rom_wr_count <= rom_wr_count + 8'd1;
      end else begin
        rom_wr_count <= rom_wr_count;
      end
    end
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed bench: a default responder and a READ_LATENCY=2/WAIT_STATES=2 one,
// each backed by a behavioural synchronous memory of matching latency.
module tb_proc_mem_responder;

  logic clk;
  logic RES;
  int   total;
  int   bad;

  proc_mem_responder_if bus_a ();
  proc_mem_responder_if bus_b ();

  logic        ena_a, wea_a, err_a;
  logic [15:0] addra_a;
  logic [7:0]  dina_a, douta_a, cnt_a;
  logic        ena_b, wea_b, err_b;
  logic [15:0] addra_b;
  logic [7:0]  dina_b, douta_b, cnt_b;

  proc_mem_responder dut_a (
    .PHI_2(clk), .RES(RES), .bus(bus_a),
    .ena(ena_a), .wea(wea_a), .addra(addra_a), .dina(dina_a), .douta(douta_a),
    .rom_wr_err(err_a), .rom_wr_count(cnt_a)
  );

  proc_mem_responder #(.READ_LATENCY(2), .WAIT_STATES(2)) dut_b (
    .PHI_2(clk), .RES(RES), .bus(bus_b),
    .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b), .douta(douta_b),
    .rom_wr_err(err_b), .rom_wr_count(cnt_b)
  );

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  rd_a1, rd_b1, rd_b2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memories: latency 1 for dut_a, latency 2 for dut_b, plus a preload port
  always @(posedge clk) begin
    if (bd_we) begin
      mem_a[bd_addr] <= bd_data;
      mem_b[bd_addr] <= bd_data;
    end else begin
      if (ena_a && wea_a) mem_a[addra_a] <= dina_a;
      if (ena_b && wea_b) mem_b[addra_b] <= dina_b;
    end
    if (ena_a && !wea_a) rd_a1 <= mem_a[addra_a];
    if (ena_b && !wea_b) rd_b1 <= mem_b[addra_b];
    rd_b2 <= rd_b1;
  end

  assign douta_a = rd_a1;
  assign douta_b = rd_b2;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic sync_a;
    int n;
    n = 0;
    @(negedge clk);
    while (bus_a.RDY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus_a.RDY !== 1'b1) begin bad++; $display("FAIL sync_a: RDY=%b want 1 within 20 cycles", bus_a.RDY); end
    step();
  endtask

  task automatic sync_b;
    int n;
    n = 0;
    @(negedge clk);
    while (bus_b.RDY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus_b.RDY !== 1'b1) begin bad++; $display("FAIL sync_b: RDY=%b want 1 within 20 cycles", bus_b.RDY); end
    step();
  endtask

  task automatic test_reset;
    total++; if (bus_a.RDY !== 1'b1)    begin bad++; $display("FAIL rst_rdy: got %b want 1", bus_a.RDY); end
    total++; if (ena_a !== 1'b0)        begin bad++; $display("FAIL rst_ena: got %b want 0", ena_a); end
    total++; if (wea_a !== 1'b0)        begin bad++; $display("FAIL rst_wea: got %b want 0", wea_a); end
    total++; if (addra_a !== 16'h0000)  begin bad++; $display("FAIL rst_addra: got %h want 0000", addra_a); end
    total++; if (dina_a !== 8'h00)      begin bad++; $display("FAIL rst_dina: got %h want 00", dina_a); end
    total++; if (bus_a.DB_IN !== 8'h00) begin bad++; $display("FAIL rst_dbin: got %h want 00", bus_a.DB_IN); end
    total++; if (cnt_a !== 8'h00)       begin bad++; $display("FAIL rst_count: got %h want 00", cnt_a); end
    total++; if (err_a !== 1'b0)        begin bad++; $display("FAIL rst_err: got %b want 0", err_a); end
  endtask

  task automatic test_default_read;
    logic [2:0] exp_rdy;
    exp_rdy = 3'b100;
    sync_a();
    bus_a.AB = 16'h1234;
    bus_a.RW = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus_a.RDY !== exp_rdy[c]) begin bad++; $display("FAIL rd_rdy c%0d: got %b want %b", c, bus_a.RDY, exp_rdy[c]); end
      total++; if (ena_a !== (c == 0))       begin bad++; $display("FAIL rd_ena c%0d: got %b want %b", c, ena_a, (c == 0)); end
      if (c == 0) begin
        total++; if (addra_a !== 16'h1234) begin bad++; $display("FAIL rd_addra: got %h want 1234", addra_a); end
        total++; if (wea_a !== 1'b0)       begin bad++; $display("FAIL rd_wea: got %b want 0", wea_a); end
      end
      if (c == 2) begin
        total++; if (bus_a.DB_IN !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", bus_a.DB_IN); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_read;
    logic [2:0] exp_rdy;
    exp_rdy = 3'b100;
    sync_a();
    bus_a.AB = 16'h0010;
    bus_a.RW = 1'b1;
    step();
    RES = 1'b0;
    #1;
    total++; if (bus_a.RDY !== 1'b1)    begin bad++; $display("FAIL mid_rst_rdy: got %b want 1", bus_a.RDY); end
    total++; if (ena_a !== 1'b0)        begin bad++; $display("FAIL mid_rst_ena: got %b want 0", ena_a); end
    total++; if (bus_a.DB_IN !== 8'h00) begin bad++; $display("FAIL mid_rst_dbin: got %h want 00", bus_a.DB_IN); end
    step();
    total++; if (ena_a !== 1'b0)        begin bad++; $display("FAIL mid_rst_hold_ena: got %b want 0", ena_a); end
    bus_a.AB = 16'h1234;
    RES = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus_a.RDY !== exp_rdy[c]) begin bad++; $display("FAIL post_rst_rdy c%0d: got %b want %b", c, bus_a.RDY, exp_rdy[c]); end
      if (c == 1) begin
        total++; if (bus_a.DB_IN !== 8'h00) begin bad++; $display("FAIL post_rst_early: got %h want 00", bus_a.DB_IN); end
      end
      if (c == 2) begin
        total++; if (bus_a.DB_IN !== 8'hA5) begin bad++; $display("FAIL post_rst_data: got %h want a5", bus_a.DB_IN); end
      end
      step();
    end
  endtask

  task automatic test_writes;
    logic [15:0] wa [2];
    logic [7:0]  wd [2];
    wa[0] = 16'h0200; wd[0] = 8'h3C;
    wa[1] = 16'h0201; wd[1] = 8'h5A;
    sync_a();
    for (int i = 0; i < 2; i++) begin
      bus_a.AB     = wa[i];
      bus_a.RW     = 1'b0;
      bus_a.DB_OUT = wd[i];
      @(negedge clk);
      total++; if (ena_a !== 1'b1 || wea_a !== 1'b1) begin bad++; $display("FAIL wr_en %0d: got ena=%b wea=%b want 1 1", i, ena_a, wea_a); end
      total++; if (bus_a.RDY !== 1'b1)   begin bad++; $display("FAIL wr_rdy %0d: got %b want 1", i, bus_a.RDY); end
      total++; if (addra_a !== wa[i])    begin bad++; $display("FAIL wr_addra %0d: got %h want %h", i, addra_a, wa[i]); end
      total++; if (dina_a !== wd[i])     begin bad++; $display("FAIL wr_dina %0d: got %h want %h", i, dina_a, wd[i]); end
      total++; if (bus_a.DB_IN !== 8'hA5) begin bad++; $display("FAIL wr_dbin_hold %0d: got %h want a5", i, bus_a.DB_IN); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      bus_a.AB = wa[i];
      bus_a.RW = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (c == 2) begin
          total++; if (bus_a.DB_IN !== wd[i]) begin bad++; $display("FAIL wr_readback %0d: got %h want %h", i, bus_a.DB_IN, wd[i]); end
        end
        step();
      end
    end
  endtask

  task automatic test_rom_write;
    sync_a();
    bus_a.AB     = 16'hDFFF;
    bus_a.RW     = 1'b0;
    bus_a.DB_OUT = 8'h42;
    @(negedge clk);
    total++; if (wea_a !== 1'b1) begin bad++; $display("FAIL rom_edge_ram_wea: got %b want 1", wea_a); end
    step();
    bus_a.AB     = 16'hFFFC;
    bus_a.DB_OUT = 8'h99;
    @(negedge clk);
    total++; if (ena_a !== 1'b0 || wea_a !== 1'b0) begin bad++; $display("FAIL rom_en: got ena=%b wea=%b want 0 0", ena_a, wea_a); end
    total++; if (bus_a.RDY !== 1'b1) begin bad++; $display("FAIL rom_rdy: got %b want 1", bus_a.RDY); end
    total++; if (err_a !== 1'b0)     begin bad++; $display("FAIL rom_err_early: got %b want 0", err_a); end
    step();
    bus_a.RW = 1'b1;
    @(negedge clk);
    total++; if (err_a !== 1'b1)     begin bad++; $display("FAIL rom_err_pulse: got %b want 1", err_a); end
    total++; if (cnt_a !== 8'd1)     begin bad++; $display("FAIL rom_count1: got %0d want 1", cnt_a); end
    step();
    @(negedge clk);
    total++; if (err_a !== 1'b0)     begin bad++; $display("FAIL rom_err_end: got %b want 0", err_a); end
    step();
    @(negedge clk);
    total++; if (bus_a.DB_IN !== 8'hEE) begin bad++; $display("FAIL rom_unchanged: got %h want ee", bus_a.DB_IN); end
    total++; if (mem_a[16'hDFFF] !== 8'h42) begin bad++; $display("FAIL rom_edge_ram_mem: got %h want 42", mem_a[16'hDFFF]); end
    step();
    bus_a.AB = 16'hE000;
    bus_a.RW = 1'b0;
    for (int i = 0; i < 300; i++) step();
    bus_a.AB = 16'h1234;
    bus_a.RW = 1'b1;
    @(negedge clk);
    total++; if (cnt_a !== 8'hFF) begin bad++; $display("FAIL rom_saturate: got %0d want 255", cnt_a); end
    total++; if (err_a !== 1'b1)  begin bad++; $display("FAIL rom_err_last: got %b want 1", err_a); end
    step();
  endtask

  task automatic test_mixed;
    int ena_n;
    int wea_n;
    ena_n = 0;
    wea_n = 0;
    sync_a();
    bus_a.AB = 16'h0010;
    bus_a.RW = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ena_a === 1'b1) ena_n++;
      if (wea_a === 1'b1) wea_n++;
      if (c == 2) begin
        total++; if (bus_a.DB_IN !== 8'h11) begin bad++; $display("FAIL mix_first: got %h want 11", bus_a.DB_IN); end
      end
      step();
    end
    bus_a.RW     = 1'b0;
    bus_a.DB_OUT = 8'h77;
    @(negedge clk);
    if (ena_a === 1'b1) ena_n++;
    if (wea_a === 1'b1) wea_n++;
    step();
    bus_a.RW = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ena_a === 1'b1) ena_n++;
      if (wea_a === 1'b1) wea_n++;
      if (c == 2) begin
        total++; if (bus_a.DB_IN !== 8'h77) begin bad++; $display("FAIL mix_final: got %h want 77", bus_a.DB_IN); end
      end
      step();
    end
    total++; if (ena_n != 3) begin bad++; $display("FAIL mix_ena_count: got %0d want 3", ena_n); end
    total++; if (wea_n != 1) begin bad++; $display("FAIL mix_wea_count: got %0d want 1", wea_n); end
  endtask

  task automatic test_wait_states;
    int ena_n;
    int wea_n;
    ena_n = 0;
    wea_n = 0;
    sync_b();
    bus_b.AB = 16'h0300;
    bus_b.RW = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ena_b === 1'b1) ena_n++;
      total++; if (bus_b.RDY !== (c == 5)) begin bad++; $display("FAIL ws_rd_rdy c%0d: got %b want %b", c, bus_b.RDY, (c == 5)); end
      if (c == 5) begin
        total++; if (bus_b.DB_IN !== 8'hC7) begin bad++; $display("FAIL ws_rd_data: got %h want c7", bus_b.DB_IN); end
      end
      step();
    end
    total++; if (ena_n != 1) begin bad++; $display("FAIL ws_rd_ena_count: got %0d want 1", ena_n); end
    bus_b.RW     = 1'b0;
    bus_b.DB_OUT = 8'hD2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wea_b === 1'b1) wea_n++;
      total++; if (bus_b.RDY !== (c == 2)) begin bad++; $display("FAIL ws_wr_rdy c%0d: got %b want %b", c, bus_b.RDY, (c == 2)); end
      step();
    end
    total++; if (wea_n != 1) begin bad++; $display("FAIL ws_wr_wea_count: got %0d want 1", wea_n); end
    bus_b.RW = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        total++; if (bus_b.DB_IN !== 8'hC7) begin bad++; $display("FAIL ws_rd2_early: got %h want c7", bus_b.DB_IN); end
      end
      if (c == 5) begin
        total++; if (bus_b.DB_IN !== 8'hD2) begin bad++; $display("FAIL ws_rd2_data: got %h want d2", bus_b.DB_IN); end
      end
      step();
    end
    ena_n = 0;
    bus_b.AB = 16'hF000;
    bus_b.RW = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ena_b === 1'b1) ena_n++;
      total++; if (bus_b.RDY !== (c == 2)) begin bad++; $display("FAIL ws_rom_rdy c%0d: got %b want %b", c, bus_b.RDY, (c == 2)); end
      if (c == 1) begin
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL ws_rom_err: got %b want 1", err_b); end
      end
      if (c == 2) begin
        total++; if (cnt_b !== 8'd1) begin bad++; $display("FAIL ws_rom_count: got %0d want 1", cnt_b); end
      end
      step();
    end
    total++; if (ena_n != 0) begin bad++; $display("FAIL ws_rom_ena_count: got %0d want 0", ena_n); end
    bus_b.AB = 16'h0000;
    bus_b.RW = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bd_we = 1'b0;
    bd_addr = 16'h0000;
    bd_data = 8'h00;
    bus_a.AB = 16'h1234; bus_a.RW = 1'b1; bus_a.DB_OUT = 8'h00;
    bus_b.AB = 16'h0000; bus_b.RW = 1'b1; bus_b.DB_OUT = 8'h00;
    RES = 1'b1;
    #2;
    RES = 1'b0;
    bd_write(16'h1234, 8'hA5);
    bd_write(16'h0010, 8'h11);
    bd_write(16'hFFFC, 8'hEE);
    bd_write(16'h0000, 8'h00);
    bd_write(16'h0300, 8'hC7);
    test_reset();
    RES = 1'b1;
    test_default_read();
    test_reset_mid_read();
    test_writes();
    test_rom_write();
    test_mixed();
    test_wait_states();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Memory-side responder for the 6502 core's bus (AB, RW, DB_OUT in; DB_IN, RDY out).
- Converts each CPU bus cycle into an access on the synchronous single-port memory_array port (ena/wea/addra/dina/douta).
- Inserts RDY stall cycles to cover memory read latency plus programmable wait states.
- Write-protects a ROM region and counts rejected writes.

Parameters:
- MEM_ADDR_WIDTH, 16: width of addra; AB[MEM_ADDR_WIDTH-1:0] is used.
- READ_LATENCY, 1: cycles from ena to valid douta; legal range 1..4.
- WAIT_STATES, 0: extra stall cycles added to every access; legal range 0..7.
- ROM_BASE, 16'hE000: addresses at or above this value are read-only.

Ports:
- PHI_2  in  1  system clock; all state updates on rising edge.
- RES  in  1  reset; asynchronous, active-low.
- AB  in  16  CPU address; held stable by the CPU while RDY=0.
- RW  in  1  1 = read, 0 = write.
- DB_OUT  in  8  CPU write data.
- DB_IN  out  8  read data to CPU; registered.
- RDY  out  1  1 = cycle completes; 0 = CPU stalls (holds AB/RW/DB_OUT).
- ena  out  1  memory port enable.
- wea  out  1  memory write enable.
- addra  out  MEM_ADDR_WIDTH  memory address.
- dina  out  8  memory write data.
- douta  in  8  memory read data, valid READ_LATENCY cycles after ena.
- rom_wr_err  out  1  one-cycle pulse per rejected ROM write.
- rom_wr_count  out  8  rejected-write counter; saturates at 255.

Behaviour:
- Reset (RES=0, asynchronous):
  - State -> IDLE; DB_IN=8'h00; rom_wr_count=0; rom_wr_err=0; internal counters cleared.
  - While RES=0: RDY=1, ena=0, wea=0, addra=0, dina=0.
  - Reset asserted mid-access abandons the access; no memory write is issued after reset asserts.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, RW=1 (read):
  - Combinational: ena=1, wea=0, addra=AB, RDY=0.
  - Next state RD_WAIT; load counter = READ_LATENCY + WAIT_STATES.
- RD_WAIT:
  - ena=0, RDY=0.
  - Capture douta into DB_IN at the edge ending cycle READ_LATENCY after issue.
  - Counter decrements each cycle; on reaching 0, go to DONE.
- DONE:
  - RDY=1, ena=0; DB_IN holds the read data.
  - Next state IDLE unconditionally.
- Read total: 2 + READ_LATENCY + WAIT_STATES cycles, RDY=1 only in the last cycle. Defaults give RDY 0,0,1.
- IDLE, RW=0, AB < ROM_BASE:
  - Combinational: ena=1, wea=1, addra=AB, dina=DB_OUT.
  - WAIT_STATES=0: RDY=1, stay in IDLE (one-cycle write; back-to-back writes every cycle).
  - WAIT_STATES>0: RDY=0; go to WR_WAIT with counter=WAIT_STATES.
- IDLE, RW=0, AB >= ROM_BASE:
  - ena=0, wea=0.
  - rom_wr_err=1 in the following cycle.
  - rom_wr_count increments, holding at 8'hFF.
  - RDY and wait-state timing are identical to a legal write.
- WR_WAIT:
  - ena=0, wea=0 (memory written exactly once per access).
  - RDY=0 until counter expires, then RDY=1 for one cycle and return to IDLE.
- DB_IN:
  - Unchanged by writes.
  - Holds the last read value until the next read capture.
- AB/RW changes while RDY=0 are protocol violations; the block uses values sampled at issue.
- Address compare uses the full 16-bit AB. addra truncates to MEM_ADDR_WIDTH (wrap-around aliasing).

Test Plan:
- Reset mid-read: assert RES=0 while in RD_WAIT -> immediately RDY=1, ena=0, DB_IN=00; after release, a read of 0x1234 completes normally.
- Default read: mem[0x1234]=A5, AB=0x1234 RW=1 -> RDY 0,0,1; ena=1 only in first cycle with addra=0x1234; DB_IN=A5 in third cycle.
- Writes: AB=0x0200 RW=0 DB_OUT=3C, then AB=0x0201 DB_OUT=5A on consecutive cycles -> ena=wea=1 each cycle, RDY=1 throughout; subsequent reads return 3C and 5A.
- ROM write: AB=0xFFFC RW=0 -> wea=0, mem unchanged, rom_wr_err pulses one cycle, count=1; 300 ROM writes -> count=255.
- READ_LATENCY=2, WAIT_STATES=2: read -> RDY low 5 cycles then high 1; write -> RDY low 2 cycles then high; wea asserted exactly one cycle.
- Mixed sequence read 0x0010, write 0x0010=77, read 0x0010 -> first DB_IN = prior value, final DB_IN=77, no dropped or duplicated ena pulses.
